// File: rtl/cpu_axi_master_if.sv
// AXI4 channel bundle between cpu_axi_master and its responder.
// Single-beat writes, INCR read bursts; IDs are carried but not checked.
interface cpu_axi_master_if;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;

   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;

   logic [3:0]  AWID;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;

   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;

   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY,
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY,
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY
   );
endinterface

// File: rtl/cpu_axi_master.sv
// Core-request to AXI4 bridge: one outstanding transaction, read bursts
// passed through combinationally, single-beat writes, sticky error per transaction.
//
// state  | meaning
// S_IDLE | ready for a core request, all bus outputs parked at 0
// S_AR   | read address presented, waiting for ARREADY
// S_R    | collecting read beats until RLAST
// S_AW   | write address presented, waiting for AWREADY
// S_W    | single write beat presented, waiting for WREADY
// S_B    | waiting for the write response
module cpu_axi_master #(
    parameter logic [3:0] MASTER_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [3:0]  req_len,
    output logic        rsp_rvalid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_done,
    output logic        rsp_err,
    cpu_axi_master_if.master axi
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_cnt;
    logic        err_q;

    // IDs are not checked; the responder is expected to echo MASTER_ID.
    wire unused_ids = ^{axi.RID, axi.BID};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                beat_cnt <= '0;
                err_q    <= 1'b0;
                if (req_valid) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    wstrb_q <= req_wstrb;
                    len_q   <= req_len;
                end
            end
            // A beat arriving at count 15 without RLAST overruns the burst; the counter wraps.
            if (state == S_R && axi.RVALID) begin
                beat_cnt <= beat_cnt + 4'd1;
                if (axi.RRESP != 2'b00 || (!axi.RLAST && beat_cnt == 4'd15))
                    err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_rvalid  = 1'b0;
        rsp_rdata   = '0;
        rsp_done    = 1'b0;
        rsp_err     = 1'b0;
        axi.ARID    = '0;
        axi.ARADDR  = '0;
        axi.ARLEN   = '0;
        axi.ARSIZE  = '0;
        axi.ARBURST = '0;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;
        axi.AWID    = '0;
        axi.AWADDR  = '0;
        axi.AWLEN   = '0;
        axi.AWSIZE  = '0;
        axi.AWBURST = '0;
        axi.AWVALID = 1'b0;
        axi.WDATA   = '0;
        axi.WSTRB   = '0;
        axi.WLAST   = 1'b0;
        axi.WVALID  = 1'b0;
        axi.BREADY  = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_write ? S_AW : S_AR;
            end
            S_AR: begin
                axi.ARVALID = 1'b1;
                axi.ARID    = MASTER_ID;
                axi.ARADDR  = addr_q;
                axi.ARLEN   = len_q;
                axi.ARSIZE  = 3'b010;
                axi.ARBURST = 2'b01;
                if (axi.ARREADY) state_nxt = S_R;
            end
            S_R: begin
                axi.RREADY = 1'b1;
                if (axi.RVALID) begin
                    rsp_rvalid = 1'b1;
                    rsp_rdata  = axi.RDATA;
                    if (axi.RLAST) begin
                        rsp_done  = 1'b1;
                        rsp_err   = err_q || (axi.RRESP != 2'b00) || (beat_cnt != len_q);
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_AW: begin
                axi.AWVALID = 1'b1;
                axi.AWID    = MASTER_ID;
                axi.AWADDR  = addr_q;
                axi.AWLEN   = 4'd0;
                axi.AWSIZE  = 3'b010;
                axi.AWBURST = 2'b01;
                if (axi.AWREADY) state_nxt = S_W;
            end
            S_W: begin
                axi.WVALID = 1'b1;
                axi.WLAST  = 1'b1;
                axi.WDATA  = wdata_q;
                axi.WSTRB  = wstrb_q;
                if (axi.WREADY) state_nxt = S_B;
            end
            S_B: begin
                axi.BREADY = 1'b1;
                if (axi.BVALID) begin
                    rsp_done  = 1'b1;
                    rsp_err   = err_q || (axi.BRESP != 2'b00);
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master: inputs driven on the falling edge,
// outputs checked 1 time unit later, responder behaviour scripted per step.
module tb_cpu_axi_master;

    localparam logic [3:0] MID = 4'hA;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb, req_len;
    logic        rsp_rvalid, rsp_done, rsp_err;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    cpu_axi_master_if axi();

    cpu_axi_master #(.MASTER_ID(MID)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_len    (req_len),
        .rsp_rvalid (rsp_rvalid),
        .rsp_rdata  (rsp_rdata),
        .rsp_done   (rsp_done),
        .rsp_err    (rsp_err),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at the next falling edge with req_valid low.
    task automatic accept(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [3:0] l, input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        req_wstrb = s;    req_len = l;
        #1 chk({tag, ".req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int aw_delay, input logic [1:0] bresp,
                      input logic exp_err);
        accept(1'b1, a, d, s, 4'd7, tag);
        for (int i = 0; i <= aw_delay; i++) begin
            axi.AWREADY = (i == aw_delay);
            #1;
            chk({tag, ".awvalid"}, axi.AWVALID, 1);
            chk({tag, ".awaddr"},  axi.AWADDR, a);
            chk({tag, ".awlen"},   axi.AWLEN, 0);
            chk({tag, ".awsize"},  axi.AWSIZE, 3'b010);
            chk({tag, ".awburst"}, axi.AWBURST, 2'b01);
            chk({tag, ".awid"},    axi.AWID, MID);
            chk({tag, ".wvalid_early"}, axi.WVALID, 0);
            chk({tag, ".req_ready_busy"}, req_ready, 0);
            @(negedge clk);
        end
        axi.AWREADY = 1'b0; axi.WREADY = 1'b1;
        #1;
        chk({tag, ".wvalid"},  axi.WVALID, 1);
        chk({tag, ".wlast"},   axi.WLAST, 1);
        chk({tag, ".wdata"},   axi.WDATA, d);
        chk({tag, ".wstrb"},   axi.WSTRB, s);
        chk({tag, ".aw_in_w"}, axi.AWVALID, 0);
        @(negedge clk);
        axi.WREADY = 1'b0; axi.BVALID = 1'b1; axi.BRESP = bresp; axi.BID = MID;
        #1;
        chk({tag, ".bready"},   axi.BREADY, 1);
        chk({tag, ".rsp_done"}, rsp_done, 1);
        chk({tag, ".rsp_err"},  rsp_err, exp_err);
        @(negedge clk);
        axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        #1;
        chk({tag, ".done_clear"}, rsp_done, 0);
        chk({tag, ".idle_ready"}, req_ready, 1);
    endtask

    // Read with nbeats returned; a stall cycle precedes beat i when stall_mask[i]; RLAST on the final beat.
    task automatic rd(input string tag, input logic [31:0] a, input logic [3:0] l, input int nbeats,
                      input logic [31:0] stall_mask, input int err_beat, input logic exp_err);
        accept(1'b0, a, 32'h0, 4'hF, l, tag);
        axi.ARREADY = 1'b1;
        #1;
        chk({tag, ".arvalid"}, axi.ARVALID, 1);
        chk({tag, ".araddr"},  axi.ARADDR, a);
        chk({tag, ".arlen"},   axi.ARLEN, l);
        chk({tag, ".arsize"},  axi.ARSIZE, 3'b010);
        chk({tag, ".arburst"}, axi.ARBURST, 2'b01);
        chk({tag, ".arid"},    axi.ARID, MID);
        chk({tag, ".rready_ar"}, axi.RREADY, 0);
        @(negedge clk);
        axi.ARREADY = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (stall_mask[i]) begin
                axi.RVALID = 1'b0;
                #1;
                chk({tag, ".stall_rvalid"}, rsp_rvalid, 0);
                chk({tag, ".stall_rready"}, axi.RREADY, 1);
                chk({tag, ".stall_done"},   rsp_done, 0);
                @(negedge clk);
            end
            axi.RVALID = 1'b1;
            axi.RDATA  = 32'hA000_0000 + i;
            axi.RLAST  = (i == nbeats - 1);
            axi.RRESP  = (i == err_beat) ? 2'b10 : 2'b00;
            axi.RID    = MID;
            #1;
            chk({tag, ".rsp_rvalid"}, rsp_rvalid, 1);
            chk({tag, ".rsp_rdata"},  rsp_rdata, 32'hA000_0000 + i);
            chk({tag, ".rsp_done"},   rsp_done, (i == nbeats - 1));
            if (i == nbeats - 1) chk({tag, ".rsp_err"}, rsp_err, exp_err);
            @(negedge clk);
        end
        axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
        #1;
        chk({tag, ".done_clear"}, rsp_done, 0);
        chk({tag, ".idle_ready"}, req_ready, 1);
        chk({tag, ".idle_rready"}, axi.RREADY, 0);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = 4'hF; req_len = '0;
        axi.ARREADY = 1'b0; axi.RID = '0; axi.RDATA = '0; axi.RRESP = '0;
        axi.RLAST = 1'b0; axi.RVALID = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BID = '0; axi.BRESP = '0; axi.BVALID = 1'b0;
        #1;
        chk("reset.req_ready", req_ready, 1);
        chk("reset.arvalid",   axi.ARVALID, 0);
        chk("reset.awvalid",   axi.AWVALID, 0);
        chk("reset.wvalid",    axi.WVALID, 0);
        chk("reset.rready",    axi.RREADY, 0);
        chk("reset.bready",    axi.BREADY, 0);
        chk("reset.rsp_done",  rsp_done, 0);
        chk("reset.rsp_err",   rsp_err, 0);
        chk("reset.rsp_rvalid", rsp_rvalid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single read, immediate ARREADY.
        accept(1'b0, 32'h0000_0010, 32'h0, 4'hF, 4'd0, "single");
        axi.ARREADY = 1'b1;
        #1;
        chk("single.arvalid", axi.ARVALID, 1);
        chk("single.araddr",  axi.ARADDR, 32'h10);
        chk("single.arlen",   axi.ARLEN, 0);
        @(negedge clk);
        axi.ARREADY = 1'b0; axi.RVALID = 1'b1; axi.RDATA = 32'hDEAD_BEEF; axi.RLAST = 1'b1;
        axi.RID = MID;
        #1;
        chk("single.rsp_rvalid", rsp_rvalid, 1);
        chk("single.rsp_rdata",  rsp_rdata, 32'hDEAD_BEEF);
        chk("single.rsp_done",   rsp_done, 1);
        chk("single.rsp_err",    rsp_err, 0);
        @(negedge clk);
        axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        #1;
        chk("single.idle_ready",  req_ready, 1);
        chk("single.idle_rvalid", rsp_rvalid, 0);

        // Burst of 4 with stalls before beats 1 and 3.
        rd("burst", 32'h0000_0100, 4'd3, 4, 32'b1010, -1, 1'b0);

        // Write with AWREADY delayed 3 cycles: AWVALID held for 4 cycles.
        wr("write", 32'h20, 32'h1234_5678, 4'b0000, 3, 2'b00, 1'b0);

        // Error responses.
        wr("berr", 32'h24, 32'hCAFE_F00D, 4'b1100, 0, 2'b10, 1'b1);
        rd("short_last", 32'h200, 4'd3, 2, 32'b0, -1, 1'b1);
        rd("rresp_err", 32'h300, 4'd1, 2, 32'b0, 0, 1'b1);
        rd("wrap", 32'h400, 4'd0, 17, 32'b0, -1, 1'b1);
        rd("clean_after_err", 32'h500, 4'd0, 1, 32'b0, -1, 1'b0);

        // Reset in R after 2 of 4 beats.
        accept(1'b0, 32'h600, 32'h0, 4'hF, 4'd3, "rst_mid");
        axi.ARREADY = 1'b1;
        @(negedge clk);
        axi.ARREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.RVALID = 1'b1; axi.RDATA = 32'hB000_0000 + i; axi.RLAST = 1'b0;
            @(negedge clk);
        end
        axi.RDATA = 32'hB000_0002;
        rst = 1'b0;
        #1;
        chk("rst_mid.rready",     axi.RREADY, 0);
        chk("rst_mid.rsp_rvalid", rsp_rvalid, 0);
        chk("rst_mid.rsp_rdata",  rsp_rdata, 0);
        chk("rst_mid.rsp_done",   rsp_done, 0);
        chk("rst_mid.req_ready",  req_ready, 1);
        @(negedge clk);
        axi.RVALID = 1'b0;
        rst = 1'b1;
        rd("after_rst", 32'h700, 4'd1, 2, 32'b0, -1, 1'b0);

        // Back-to-back write then read with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55AA_33CC;
        req_wstrb = 4'b1010; req_len = 4'd0;
        #1 chk("b2b.accept_wr", req_ready, 1);
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h50; axi.AWREADY = 1'b1;
        #1;
        chk("b2b.awvalid", axi.AWVALID, 1);
        chk("b2b.busy_aw", req_ready, 0);
        @(negedge clk);
        axi.AWREADY = 1'b0; axi.WREADY = 1'b1;
        #1;
        chk("b2b.wstrb",  axi.WSTRB, 4'b1010);
        chk("b2b.busy_w", req_ready, 0);
        @(negedge clk);
        axi.WREADY = 1'b0; axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        #1;
        chk("b2b.wr_done", rsp_done, 1);
        chk("b2b.busy_b",  req_ready, 0);
        @(negedge clk);
        axi.BVALID = 1'b0;
        #1;
        chk("b2b.accept_rd", req_ready, 1);
        chk("b2b.gap_done",  rsp_done, 0);
        @(negedge clk);
        req_valid = 1'b0; axi.ARREADY = 1'b1;
        #1;
        chk("b2b.arvalid", axi.ARVALID, 1);
        chk("b2b.araddr",  axi.ARADDR, 32'h50);
        @(negedge clk);
        axi.ARREADY = 1'b0; axi.RVALID = 1'b1; axi.RLAST = 1'b1; axi.RDATA = 32'h0BAD_F00D;
        #1;
        chk("b2b.rd_data", rsp_rdata, 32'h0BAD_F00D);
        chk("b2b.rd_done", rsp_done, 1);
        chk("b2b.rd_err",  rsp_err, 0);
        @(negedge clk);
        axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        #1 chk("b2b.idle", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
